// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The TRAP state exists only when FETCH_MISALIGN_TRAP_EN is defined.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    StBoot,
    StFetch,
    StWait,
`ifdef FETCH_MISALIGN_TRAP_EN
    StExec,
    StTrap
`else
    StExec
`endif
  } fetch_state_t;

endpackage

// File: rtl/next_pc_logic.sv
// Next-PC computation: PC+4 adder, target select and target alignment check.
// The selected target is always word-aligned; misaligned_o reports a dropped low pair.
module next_pc_logic #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            pc_sel_i,
  input  logic [XLEN-1:0] pc_target_i,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] pc_next_o,
  output logic            misaligned_o
);

  // Modulo-2^XLEN add: the top word wraps to zero.
  assign pc_plus4_o   = pc_i + XLEN'(4);
  assign pc_next_o    = pc_sel_i ? {pc_target_i[XLEN-1:2], 2'b00} : pc_plus4_o;
  assign misaligned_o = pc_sel_i & (pc_target_i[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding word request, registered instruction, PC update on
// retire. Define FETCH_MISALIGN_TRAP_EN to trap on misaligned taken targets.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            PC_sel,
  input  logic [XLEN-1:0] pc_target,
  input  logic            instr_retire,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_misaligned
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_next;
  logic [31:0]     instr_q;
  logic            pc_load;
  logic            instr_load;
  logic            target_misaligned;

  next_pc_logic #(
    .XLEN (XLEN)
  ) u_next_pc (
    .pc_i         (pc_q),
    .pc_sel_i     (PC_sel),
    .pc_target_i  (pc_target),
    .pc_plus4_o   (pc_plus4),
    .pc_next_o    (pc_next),
    .misaligned_o (target_misaligned)
  );

  always_comb begin
    state_d    = state_q;
    pc_load    = 1'b0;
    instr_load = 1'b0;
    unique case (state_q)
      StBoot:  state_d = StFetch;
      StFetch: state_d = StWait;
      StWait: begin
        if (imem_rvalid) begin
          instr_load = 1'b1;
          state_d    = StExec;
        end
      end
      StExec: begin
        if (instr_retire) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          if (target_misaligned) begin
            state_d = StTrap;
          end else begin
            pc_load = 1'b1;
            state_d = StFetch;
          end
`else
          pc_load = 1'b1;
          state_d = StFetch;
`endif
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      StTrap:  state_d = StTrap;
`endif
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      if (pc_load) begin
        pc_q <= pc_next;
      end
      if (instr_load) begin
        instr_q <= imem_rdata;
      end
    end
  end

  assign imem_req    = (state_q == StFetch);
  assign instr_valid = (state_q == StExec);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  // TRAP is terminal until reset, so the state itself is the sticky flag.
  assign fetch_misaligned = (state_q == StTrap);
`else
  logic unused_misaligned;
  assign unused_misaligned = target_misaligned;
  assign fetch_misaligned  = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the single-cycle RV32I core.
- Holds the architectural PC and issues one word request at a time to instruction memory.
- Registers the returned instruction for the decode/execute stage (controller + datapath).
- Advances the PC to PC+4 or to the datapath-computed target according to the controller's `PC_sel` when the current instruction retires.
- Supports variable-latency instruction memory through a request/response handshake.

## Interface
Parameters:
- `XLEN`, 32, data/address width.
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assertion, active-low.
- `PC_sel`  in  1  from controller; 1 = take `pc_target`, 0 = PC+4.
- `pc_target`  in  XLEN  branch/jump target from the datapath.
- `instr_retire`  in  1  execute stage consumes the current instruction this cycle.
- `imem_req`  out  1  read request strobe, one cycle wide.
- `imem_addr`  out  XLEN  request address; equals `pc`.
- `imem_rvalid`  in  1  response valid.
- `imem_rdata`  in  32  response instruction word.
- `instr`  out  32  registered instruction.
- `instr_valid`  out  1  `instr` is valid and awaiting retire.
- `pc`  out  XLEN  PC of `instr` / pending request.
- `pc_plus4`  out  XLEN  `pc`+4, used by the datapath for JAL/JALR writeback.
- `fetch_misaligned`  out  1  sticky misaligned-target flag (see Configuration).

## Operation
FSM states and transitions:
- BOOT: entered on reset. Always moves to FETCH on the next edge.
- FETCH: `imem_req`=1 with `imem_addr`=`pc`. Always moves to WAIT on the next edge.
- WAIT: waits for `imem_rvalid`. When it is seen, `instr`<=`imem_rdata` and the FSM moves to EXEC. Otherwise it stays in WAIT.
- EXEC: `instr_valid`=1. Holds until `instr_retire`=1, then updates `pc` and moves to FETCH.
- TRAP: present only when the macro is defined. Terminal; no requests are issued.

Output and data rules:
- `imem_req`=(state==FETCH). `instr_valid`=(state==EXEC). Both are decoded combinationally from the state register.
- PC update happens only in EXEC with `instr_retire`=1: `pc` <= `PC_sel` ? `pc_target` : `pc`+4. Arithmetic is modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0.
- `instr_retire` outside EXEC is ignored, as are `PC_sel` and `pc_target`.
- `imem_rvalid` outside WAIT is ignored and discarded. This covers stale responses arriving after a reset.
- At most one request is outstanding. Memory response latency is at least 1 cycle after the FETCH cycle.
- `instr` holds its last value outside EXEC and is not cleared on retire.

Reset values:
- state=BOOT, `pc`=`RESET_PC`, `instr`=32'h0000_0013 (NOP).
- `imem_req`=0, `instr_valid`=0, `fetch_misaligned`=0.
- Reset mid-transaction abandons the in-flight request. The first request after reset is to `RESET_PC`.

## Timing
- Reset released before edge 0: edge 0 BOOT→FETCH. `imem_req`=1 in cycle 1.
- With memory latency L (`imem_rvalid` L cycles after FETCH), `instr_valid` rises L+1 cycles after the FETCH cycle.
- If retire occurs in the first EXEC cycle, the next FETCH follows in the next cycle.
- Throughput with L=1: 3 cycles per instruction.
- `pc` changes exactly one edge after the retire cycle. It is stable throughout FETCH/WAIT/EXEC of a given instruction.

## Configuration
Macro `FETCH_MISALIGN_TRAP_EN`:
- Defined: a retire with `PC_sel`=1 and `pc_target[1:0]`≠0 does not load `pc`. The FSM goes to TRAP and `fetch_misaligned` goes to 1, staying set until reset. `imem_req` stays 0.
- Undefined: `pc` loads {`pc_target[XLEN-1:2]`, 2'b00}. `fetch_misaligned` is tied to 0. The TRAP state does not exist.

## Structure
- Shared package `fetch_pkg`: state enum `fetch_state_t` (BOOT, FETCH, WAIT, EXEC, TRAP), constant `NOP_INSTR`=32'h0000_0013, and default `RESET_PC`.
- One sub-module, `next_pc_logic`: combinational PC+4 adder, target mux and alignment check. It feeds the PC register in `fetch_unit`.

## Test plan
- Reset with `RESET_PC`=32'h100, memory L=1 returning 32'h00500093 → `imem_req` in cycle 1 with addr 0x100; `instr_valid`=1 with `instr`=0x00500093 in cycle 3.
- Retire with `PC_sel`=0 → next `imem_addr`=0x104. Retire with `PC_sel`=1, `pc_target`=0x200 → next `imem_addr`=0x200, `pc_plus4`=0x204.
- Memory L=4, `instr_retire` held high throughout → exactly one request per instruction; retire honoured only in EXEC; no double PC advance.
- `rst_n` pulsed low during WAIT, stale `imem_rvalid` injected one cycle after release → response ignored; fresh request to `RESET_PC`.
- `pc`=0xFFFF_FFFC, retire `PC_sel`=0 → next `imem_addr`=0x0.
- `pc_target`=0x202 with `PC_sel`=1: macro defined → `fetch_misaligned`=1, no further `imem_req`; undefined → next `imem_addr`=0x200, `fetch_misaligned`=0.
